// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter with a hold limit, for N = 2**SEL_W requesters.
// Drives sel/enab into a dec_param_enab decoder and provides the same decode as a registered one-hot gnt.
module dec_rr_arbiter #(
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2**SEL_W-1:0] req,
  input  logic                done,
  output logic [SEL_W-1:0]    sel,
  output logic                enab,
  output logic [2**SEL_W-1:0] gnt,
  output logic [1:0]          state_dbg
);

  localparam int N      = 2**SEL_W;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [N-1:0]      ONE      = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [SEL_W-1:0]    ptr;
  logic [HOLD_W-1:0]   hold;
  logic [SEL_W-1:0]    pick;
  logic                grant_start;
  logic                release_now;

  assign state_dbg = state;

  // First requester at or after ptr, searching upward with wrap.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] cand;
    pick  = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int i = 0; i < N; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Several simultaneous exit conditions collapse into one release.
  always_comb begin
    state_next  = state;
    grant_start = 1'b0;
    release_now = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_next  = GRANT;
          grant_start = 1'b1;
        end
      end
      GRANT: begin
        if (done || !req[sel] || (hold == HOLD_MAX)) begin
          state_next  = GAP;
          release_now = 1'b1;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel  <= '0;
      enab <= 1'b0;
      gnt  <= '0;
      ptr  <= '0;
      hold <= '0;
    end else if (grant_start) begin
      sel  <= pick;
      enab <= 1'b1;
      gnt  <= ONE << pick;
      hold <= HOLD_W'(1);
    end else if (release_now) begin
      enab <= 1'b0;
      gnt  <= '0;
      ptr  <= sel + SEL_W'(1);
      hold <= '0;
    end else if (state == GRANT) begin
      hold <= hold + HOLD_W'(1);
    end
  end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed bench for dec_rr_arbiter (SEL_W=3, MAX_HOLD=4): hand-computed expectations
// checked with immediate assertions, one linear stimulus sequence.
module tb_dec_rr_arbiter;

  localparam int SEL_W = 3;
  localparam int N     = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic             enab;
  logic [N-1:0]     gnt;
  logic [1:0]       state_dbg;

  int checks = 0;
  int errors = 0;

  dec_rr_arbiter #(.SEL_W(3), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .enab      (enab),
    .gnt       (gnt),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_grant(input string tag, input logic [SEL_W-1:0] exp_sel);
    logic [N-1:0] one_hot;
    one_hot = '0;
    one_hot[exp_sel] = 1'b1;
    chk({tag, "_enab"}, 32'(enab), 32'd1);
    chk({tag, "_sel"}, 32'(sel), 32'(exp_sel));
    chk({tag, "_gnt"}, 32'(gnt), 32'(one_hot));
    chk({tag, "_state"}, 32'(state_dbg), 32'(S_GRANT));
  endtask

  task automatic chk_off(input string tag, input logic [1:0] exp_state);
    chk({tag, "_enab"}, 32'(enab), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_state"}, 32'(state_dbg), 32'(exp_state));
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset applied before any clock edge
    #3;
    chk_off("reset", S_IDLE);
    chk("reset_sel", 32'(sel), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk_off("idle_no_req", S_IDLE);

    // Single requester 2, done in second grant cycle
    req = 8'h04;
    tick(1);
    chk_grant("r2_first", 3'd2);
    tick(1);
    chk_grant("r2_second", 3'd2);
    done = 1'b1;
    tick(1);
    chk_off("r2_release", S_GAP);
    chk("r2_sel_kept", 32'(sel), 32'd2);
    done = 1'b0;
    req  = '0;
    tick(1);
    chk_off("r2_idle", S_IDLE);

    // Fresh reset, then all requesting with done held: full rotation
    rst = 1'b1;
    tick(1);
    rst  = 1'b0;
    req  = 8'hFF;
    done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick(1);
      chk_grant($sformatf("rot%0d", k), SEL_W'(k % N));
      tick(1);
      chk_off($sformatf("rot%0d_gap", k), S_GAP);
      tick(1);
      chk_off($sformatf("rot%0d_idle", k), S_IDLE);
    end
    req  = '0;
    done = 1'b0;
    tick(1);
    chk_off("rot_quiet", S_IDLE);

    // Requester 0 alone, hold limit of 4 cycles (ptr=1 wraps to 0)
    req = 8'h01;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk_grant($sformatf("hold%0d", k + 1), 3'd0);
    end
    tick(1);
    chk_off("hold_gap", S_GAP);
    tick(1);
    chk_off("hold_idle", S_IDLE);
    tick(1);
    chk_grant("hold_regrant", 3'd0);

    // done coinciding with hold=4 must release once, ptr -> 1
    tick(3);
    chk_grant("both_hold4", 3'd0);
    done = 1'b1;
    tick(1);
    chk_off("both_gap", S_GAP);
    done = 1'b0;
    req  = 8'h03;
    tick(1);
    chk_off("both_idle", S_IDLE);
    tick(1);
    chk_grant("both_next", 3'd1);
    req = 8'h00;
    tick(1);
    chk_off("drop1_gap", S_GAP);
    tick(1);

    // Requester 3 drops mid-grant while 4 and 5 request; other bits must not disturb
    req = 8'h08;
    tick(1);
    chk_grant("r3_grant", 3'd3);
    req = 8'h8C;
    tick(1);
    chk_grant("r3_other_bits", 3'd3);
    req = 8'h30;
    tick(1);
    chk_off("r3_drop_gap", S_GAP);
    tick(1);
    chk_off("r3_drop_idle", S_IDLE);
    tick(1);
    chk_grant("r4_grant", 3'd4);
    req = 8'h00;
    tick(2);
    chk_off("r4_idle", S_IDLE);

    // done while idle is ignored
    done = 1'b1;
    tick(2);
    chk_off("done_idle", S_IDLE);
    done = 1'b0;

    // Async reset mid-grant with sel=5, then restart from ptr=0
    req = 8'h20;
    tick(1);
    chk_grant("r5_grant", 3'd5);
    #2;
    rst = 1'b1;
    #1;
    chk_off("async_rst", S_IDLE);
    chk("async_rst_sel", 32'(sel), 32'd0);
    rst = 1'b0;
    req = 8'h21;
    tick(1);
    chk_grant("post_rst", 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dec_rr_arbiter.md
DEC_RR_ARBITER -- requirements
Module: dec_rr_arbiter

Interface
REQ-001 Parameter SEL_W, default 3: width of the requester index; the block serves N = 2**SEL_W requesters.
REQ-002 Parameter MAX_HOLD, default 4: maximum consecutive cycles one requester may hold the grant; legal range 1..255.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req  input  N  request lines; bit i set means requester i wants the shared resource.
REQ-006 done  input  1  current owner releases the grant; sampled only in GRANT.
REQ-007 sel  output  SEL_W  index of the granted requester; drives the inp port of a dec_param_enab instance.
REQ-008 enab  output  1  grant valid; drives the enab port of the same dec_param_enab instance.
REQ-009 gnt  output  N  registered one-hot grant: bit sel set when enab=1, all zeros when enab=0.

Function
REQ-010 All outputs SHALL be registered; there SHALL be no combinational path from req or done to any output.
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and GAP.
REQ-012 In IDLE with req=0, the FSM SHALL stay in IDLE with enab=0 and gnt=0.
REQ-013 In IDLE with req!=0, the block SHALL select the first set req bit at or after ptr, searching upward modulo N.
- On the next edge: sel = selected index, enab=1, gnt = one-hot(sel), state GRANT.
- Latency from req sampled to enab=1: 1 cycle.
REQ-014 In GRANT, the hold counter (width ceil(log2(MAX_HOLD+1))) SHALL count grant cycles, reaching 1 in the first GRANT cycle.
REQ-015 GRANT SHALL exit on the first edge where any of the following is true: done=1; req[sel]=0; hold count = MAX_HOLD.
REQ-016 On GRANT exit the block SHALL, on that edge:
- go to GAP;
- set enab=0 and gnt=0;
- set ptr = sel+1, modulo N, with wrap from N-1 to 0;
- clear the hold counter;
- keep sel at its last value.
REQ-017 When more than one exit condition is true in the same cycle, the block SHALL perform a single release with identical behaviour to REQ-016.
REQ-018 GAP SHALL last exactly one cycle with enab=0, then go to IDLE regardless of req; at least 2 idle cycles therefore separate consecutive grants.
REQ-019 Changes on req bits other than req[sel] during GRANT SHALL NOT affect the current grant.
REQ-020 done asserted in IDLE or GAP SHALL be ignored.
REQ-021 ptr SHALL change only on GRANT exit, which guarantees that no continuously requesting requester waits more than N grants.
REQ-022 The gnt bit set SHALL always equal the dec_param_enab output for the same sel and enab.

Reset
REQ-023 While rst=1, the block SHALL immediately force, independent of clk:
- state IDLE;
- sel=0, enab=0, gnt=0;
- ptr=0 and hold counter=0.
REQ-024 Reset asserted during GRANT SHALL drop enab and gnt asynchronously, with no GAP cycle.
REQ-025 After rst deasserts, the first arbitration SHALL start from ptr=0.

Verification (SEL_W=3, MAX_HOLD=4)
REQ-026 Reset, then req=8'h04 held, done=1 on the 2nd GRANT cycle -> enab=1, sel=2, gnt=8'h04 one cycle after req; enab=0 after 2 GRANT cycles.
REQ-027 req=8'hFF held, done=1 every GRANT cycle -> sel sequence 0,1,2,3,4,5,6,7,0, with each grant 1 cycle wide and separated by GAP plus IDLE.
REQ-028 req=8'h01 held, done=0 -> enab high exactly 4 cycles, then 1 GAP and 1 IDLE cycle, then regrant with sel=0, because ptr wraps and 0 is the only requester.
REQ-029 Grant to requester 3, req[3] dropped mid-grant while req=8'h30 -> enab=0 on the next edge, next grant sel=4.
REQ-030 rst pulsed mid-GRANT with sel=5 -> enab=0, gnt=8'h00 before the next clk edge; the following grant with req=8'h21 gives sel=0.
REQ-031 done=1 and hold count=4 in the same cycle -> one release, ptr advances by exactly 1.
